// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 Set-2 key-state tracker.
// Takes bytes from the keyboard receiver and acknowledges each one with a
// one-cycle read pulse. An E0/F0 prefix FSM classifies each byte, and the
// tracker keeps a held/released bitmap for NUM_KEYS programmable codes.
// Optional feature macro: PS2_KEY_TRACKER_REPEAT_EN (key_press also pulses
// on typematic repeats while a key is held).

// Per-key state: one instance per KEY_CODES entry.
module ps2_key_lane #(
    parameter logic [8:0] CODE = 9'h000
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       ev_make,
    input  logic       ev_break,
    input  logic [8:0] ev_key,
    output logic       key_down,
    output logic       key_press,
    output logic       key_release
);
    logic hit;
    assign hit = (ev_key == CODE);

    // Held flag plus one-cycle press/release pulses. Make and break never coincide.
    always_ff @(posedge clock50) begin
        if (reset) begin
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (hit && ev_make) begin
                key_down  <= 1'b1;
`ifdef PS2_KEY_TRACKER_REPEAT_EN
                key_press <= 1'b1;
`else
                key_press <= ~key_down;
`endif
            end else if (hit && ev_break) begin
                key_down    <= 1'b0;
                key_release <= key_down;
            end
        end
    end
endmodule

module ps2_key_tracker #(
    parameter int                    NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h023, 9'h01C, 9'h01B, 9'h01D},
    parameter int                    TIMEOUT   = 500000
) (
    input  logic                clock50,
    input  logic                reset,
    input  logic                scan_ready,
    input  logic [7:0]          scan_code,
    output logic                read,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                seq_error
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    logic          sr_q;
    logic [CW-1:0] tmo_cnt;
    logic          accept;
    logic          is_e0;
    logic          is_f0;
    logic          ev_make;
    logic          ev_break;
    logic          ev_ext;
    logic [8:0]    ev_key;

    // A byte is taken only on the rising edge of scan_ready.
    assign accept = scan_ready & ~sr_q;
    assign is_e0  = (scan_code == 8'hE0);
    assign is_f0  = (scan_code == 8'hF0);

    // Classify a non-prefix byte as make/break with its extended flag.
    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (accept && !is_e0 && !is_f0) begin
            case (state)
                IDLE:    ev_make = 1'b1;
                EXT:     begin ev_make  = 1'b1; ev_ext = 1'b1; end
                BRK:     ev_break = 1'b1;
                EXT_BRK: begin ev_break = 1'b1; ev_ext = 1'b1; end
                default: ev_make = 1'b0;
            endcase
        end
    end

    assign ev_key = {ev_ext, scan_code};

    // Prefix FSM, handshake and prefix timeout.
    always_ff @(posedge clock50) begin
        if (reset) begin
            state     <= IDLE;
            sr_q      <= 1'b0;
            read      <= 1'b0;
            seq_error <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            sr_q      <= scan_ready;
            read      <= accept;
            seq_error <= 1'b0;
            if (accept) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (is_e0)      state <= EXT;
                        else if (is_f0) state <= BRK;
                    end
                    EXT: begin
                        if (is_f0)       state <= EXT_BRK;
                        else if (!is_e0) state <= IDLE;
                    end
                    BRK: begin
                        // E0 after F0 is malformed: drop the break, start a new extended code.
                        if (is_e0) begin
                            state     <= EXT;
                            seq_error <= 1'b1;
                        end else if (!is_f0) begin
                            state <= IDLE;
                        end
                    end
                    EXT_BRK: begin
                        state <= IDLE;
                        if (is_e0 || is_f0) seq_error <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    state     <= IDLE;
                    seq_error <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // All table entries compare in parallel; duplicate entries all update.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        ps2_key_lane #(.CODE(KEY_CODES[i*9 +: 9])) u_lane (
            .clock50     (clock50),
            .reset       (reset),
            .ev_make     (ev_make),
            .ev_break    (ev_break),
            .ev_key      (ev_key),
            .key_down    (key_down[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 key-state tracker between the `keyboard` receiver and game/control logic. It consumes Set-2 scan bytes from `keyboard`, acknowledges each byte with a single-cycle `read` pulse, and decodes `E0` (extended) and `F0` (break) prefixes with a prefix FSM. It maintains a held/released bitmap for `NUM_KEYS` programmable key codes, plus one-cycle press and release event pulses. Scan bytes are captured in the `clock50` domain, so no logic is clocked from the receiver's strobe.

## Interface
- `NUM_KEYS`, 4, number of tracked keys (1–32).
- `KEY_CODES`, `{9'h023, 9'h01C, 9'h01B, 9'h01D}`, `NUM_KEYS*9` bits.
  - Entry i is at `[i*9 +: 9]`: bit 8 = extended, bits 7:0 = scan code.
  - Defaults: key0 = W, key1 = S, key2 = A, key3 = D.
- `TIMEOUT`, 500000, cycles a prefix state may wait for its next byte (10 ms at 50 MHz); ≥ 2.
- `clock50`  in  1  system clock (50 MHz); sole clock.
- `reset`  in  1  reset; synchronous, active-high.
- `scan_ready`  in  1  level from `keyboard`: high while an unread byte is held.
- `scan_code`  in  8  byte from `keyboard`; valid while `scan_ready` = 1.
- `read`  out  1  one-cycle acknowledge to `keyboard`.
- `key_down`  out  NUM_KEYS  1 = key currently held.
- `key_press`  out  NUM_KEYS  one-cycle pulse on a released→held transition.
- `key_release`  out  NUM_KEYS  one-cycle pulse on a held→released transition.
- `seq_error`  out  1  one-cycle pulse on a malformed prefix sequence or a timeout.

## Operation
- `sr_q` registers `scan_ready` every cycle.
  - A byte is *accepted* in cycle c when `scan_ready` = 1 and `sr_q` = 0.
  - `scan_code` is sampled in cycle c.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. Each accepted byte is handled as follows.
  - IDLE: `E0` → EXT; `F0` → BRK; any other byte → *make* event with ext = 0, stay IDLE.
  - EXT: `F0` → EXT_BRK; `E0` → EXT (repeated prefix tolerated); other → make with ext = 1, then IDLE.
  - BRK: `F0` → BRK; `E0` → EXT plus `seq_error` (pending break discarded); other → *break* event with ext = 0, then IDLE.
  - EXT_BRK: `E0` or `F0` → IDLE plus `seq_error`; other → break with ext = 1, then IDLE.
- Event match: compare `{ext, code}` against every `KEY_CODES` entry in parallel.
  - Duplicate table entries all update.
  - Codes with no matching entry change nothing and produce no pulse.
- Make on key i:
  - `key_down[i]` ← 1.
  - `key_press[i]` pulses only if `key_down[i]` was 0, so typematic repeats are silent; see Configuration.
- Break on key i:
  - `key_down[i]` ← 0.
  - `key_release[i]` pulses only if `key_down[i]` was 1.
  - A break for a key not held is silent.
- Timeout:
  - A counter clears on every accepted byte and counts while the FSM is outside IDLE.
  - When the count reaches `TIMEOUT − 1` with no byte accepted, the FSM → IDLE and `seq_error` pulses.
  - `key_down` is unaffected.
- Bytes `AA`, `FA`, `FE`, `00`, `FF` are ordinary codes. They match only if present in the table.

## Timing
- Reset values: `read` = 0, `key_down` = 0, `key_press` = 0, `key_release` = 0, `seq_error` = 0, FSM = IDLE, timeout counter = 0, `sr_q` = 0.
  - Because `sr_q` resets to 0, a byte pending across reset is accepted in the first cycle after reset.
  - Any prefix received before reset is lost.
- Accept in cycle c gives the following, all in cycle c+1:
  - `read` = 1 for exactly one cycle.
  - `key_down`, `key_press`, `key_release` and `seq_error` are updated or pulsed.
  - The FSM holds its next state.
- One byte per `scan_ready` rising edge.
  - If `scan_ready` stays high after `read`, no second accept occurs until it falls and rises again.
  - `keyboard` must drop `scan_ready` within 2 cycles of `read`.
- Reset asserted in any cycle wins over an accept in the same cycle: the byte is dropped and all outputs are 0 in the next cycle.
- Make and break cannot coincide: at most one event per cycle.
- All outputs are registered; there is no combinational path from `scan_code` to any output.

## Configuration
- `PS2_KEY_TRACKER_REPEAT_EN` defined:
  - `key_press[i]` pulses on every make for key i, including typematic repeats while held.
  - Intended for auto-repeat menus and text entry.
- Not defined: `key_press[i]` pulses only on released→held transitions.
- The macro does not affect `key_release` or `key_down`.

## Test plan
- Make/break, default table: bytes `1D`, then `F0 1D` → `key_down` = 4'b0001 one cycle after the `1D` accept; `key_press` = 4'b0001 for one cycle; after the final `1D`, `key_down` = 0 and `key_release` = 4'b0001 for one cycle; `read` pulses 3 times, once per byte.
- Extended vs plain, with key0 = 9'h175 (up arrow): `75` → no change; `E0 75` → `key_down[0]` = 1; `F0 75` → no change; `E0 F0 75` → `key_down[0]` = 0.
- Typematic: `1B 1B 1B` → `key_press[1]` pulses once without the macro and 3 times with `PS2_KEY_TRACKER_REPEAT_EN`; `key_down[1]` stays 1 throughout.
- Malformed sequence and timeout:
  - `E0 F0 E0` → one `seq_error` pulse, FSM in IDLE, `key_down` unchanged.
  - `F0` then idle for `TIMEOUT` cycles → `seq_error` pulse; a subsequent `1C` is a make (`key_down[2]` = 1), not a break.
- Reset mid-sequence: hold W, send `F0`, assert `reset` for 1 cycle, then send `1D` → all outputs 0 after reset; `1D` is a make, so `key_down[0]` = 1 again.
- Handshake: hold `scan_ready` high for 10 cycles → exactly one `read` pulse, in the cycle after the rise.
